// File: rtl/vector_inst_queue_pkg.sv
// Shared vector definitions: opcode/funct3 encodings, queue entry and queue state types.
package vector_inst_queue_pkg;

  localparam int VIQ_XLEN = 32;

  typedef enum logic [6:0] {
    V_ARITH = 7'b1010111,
    V_LOAD  = 7'b0000111
  } v_opcode_e;

  typedef enum logic [2:0] {
    CONF = 3'b111
  } v_func3_e;

  typedef struct packed {
    logic [VIQ_XLEN-1:0] inst;
    logic [VIQ_XLEN-1:0] rs1;
    logic [VIQ_XLEN-1:0] rs2;
  } vec_iq_entry_t;

  typedef enum logic {
    IQ_RUN,
    IQ_CFG_WAIT
  } vec_iq_state_e;

  // vset{i}vl{i}: V_ARITH major opcode with the CONF funct3 encoding.
  function automatic logic is_conf_inst(input logic [VIQ_XLEN-1:0] inst);
    return (inst[6:0] == V_ARITH) && (inst[14:12] == CONF);
  endfunction

endpackage

// File: rtl/vector_inst_queue_fifo_mem.sv
// Entry storage for the vector instruction queue: one write port, combinational read.
module vector_inst_queue_fifo_mem
  import vector_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = $bits(vec_iq_entry_t)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  vec_iq_entry_t mem [DEPTH];

  // Storage is cleared on reset so the head outputs read zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= vec_iq_entry_t'(wr_data);
    end
  end

  // Head entry is presented without a register stage.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/vector_inst_queue.sv
// Decoupling queue between the scalar core and vector decode, with a barrier that holds
// issue after a vset{i}vl{i} until the vector CSR block reports the write complete.
//
//  state        | meaning
//  IQ_RUN       | head issues whenever the queue holds an entry
//  IQ_CFG_WAIT  | config instruction issued; issue held until cfg_done
module vector_inst_queue
  import vector_inst_queue_pkg::*;
#(
  parameter int XLEN  = VIQ_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          vec_inst_in,
  input  logic [XLEN-1:0]          rs1_data_in,
  input  logic [XLEN-1:0]          rs2_data_in,
  input  logic                     inst_valid_in,
  output logic                     inst_ready_out,
  output logic [XLEN-1:0]          vec_inst,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     inst_valid,
  input  logic                     inst_ack,
  input  logic                     cfg_done,
  input  logic                     flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int W  = $bits(vec_iq_entry_t);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  vec_iq_state_e state;
  vec_iq_entry_t wr_entry;
  vec_iq_entry_t head;
  logic [W-1:0]  head_raw;
  logic          full;
  logic          push;
  logic          pop;

  // Handshake qualification; ready never looks at the incoming valid.
  always_comb begin
    full           = (occupancy == OW'(DEPTH));
    inst_ready_out = !full;
    inst_valid     = (state == IQ_RUN) && (occupancy != '0);
    push           = inst_valid_in && inst_ready_out;
    pop            = inst_valid && inst_ack;
  end

  // Pack the incoming instruction and operands into one entry.
  always_comb begin
    wr_entry.inst = vec_inst_in;
    wr_entry.rs1  = rs1_data_in;
    wr_entry.rs2  = rs2_data_in;
  end

  vector_inst_queue_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (push && !flush),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head_raw)
  );

  // Unpack the head entry onto the decode-side outputs.
  always_comb begin
    head     = vec_iq_entry_t'(head_raw);
    vec_inst = head.inst;
    rs1_data = head.rs1;
    rs2_data = head.rs2;
  end

  // Pointers, occupancy and barrier state; flush wins over everything else in the cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      state     <= IQ_RUN;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      state     <= IQ_RUN;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occupancy <= occupancy + OW'(1);
      else if (pop && !push) occupancy <= occupancy - OW'(1);
      case (state)
        IQ_RUN:      if (pop && is_conf_inst(head.inst)) state <= IQ_CFG_WAIT;
        IQ_CFG_WAIT: if (cfg_done) state <= IQ_RUN;
        default:     state <= IQ_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_inst_queue.sv
// Directed bench for vector_inst_queue with hand-computed expectations.
module tb_vector_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] vec_inst_in, rs1_data_in, rs2_data_in;
  logic        inst_valid_in, inst_ack, cfg_done, flush;
  logic        inst_ready_out, inst_valid;
  logic [31:0] vec_inst, rs1_data, rs2_data;
  logic [2:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  vector_inst_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .vec_inst_in    (vec_inst_in),
    .rs1_data_in    (rs1_data_in),
    .rs2_data_in    (rs2_data_in),
    .inst_valid_in  (inst_valid_in),
    .inst_ready_out (inst_ready_out),
    .vec_inst       (vec_inst),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .inst_valid     (inst_valid),
    .inst_ack       (inst_ack),
    .cfg_done       (cfg_done),
    .flush          (flush),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_valid_in = 1'b0;
    vec_inst_in   = '0;
    rs1_data_in   = '0;
    rs2_data_in   = '0;
    inst_ack      = 1'b0;
    cfg_done      = 1'b0;
    flush         = 1'b0;
  endtask

  // One clock: drive for the coming edge, then return 1 time unit after it with inputs idle.
  task automatic cyc(input logic vin, input logic [31:0] inst, input logic [31:0] r1,
                     input logic [31:0] r2, input logic ack, input logic cfg, input logic fl);
    inst_valid_in = vin;
    vec_inst_in   = inst;
    rs1_data_in   = r1;
    rs2_data_in   = r2;
    inst_ack      = ack;
    cfg_done      = cfg;
    flush         = fl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic head_is(input string tag, input logic [31:0] inst, input logic [31:0] r1,
                         input logic [31:0] r2, input logic v, input logic [2:0] occ);
    chk({tag, ".inst"},  vec_inst, inst);
    chk({tag, ".rs1"},   rs1_data, r1);
    chk({tag, ".rs2"},   rs2_data, r2);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(v));
    chk({tag, ".occ"},   32'(occupancy), 32'(occ));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    chk("rst.occ",   32'(occupancy), 0);
    chk("rst.valid", 32'(inst_valid), 0);
    chk("rst.ready", 32'(inst_ready_out), 1);
    chk("rst.inst",  vec_inst, 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Fill with four entries, no ack.
    cyc(1, 32'h0000_7057, 5, 7, 0, 0, 0);
    head_is("push1", 32'h0000_7057, 5, 7, 1, 1);
    cyc(1, 32'h0000_0057, 1, 2, 0, 0, 0);
    head_is("push2", 32'h0000_7057, 5, 7, 1, 2);
    cyc(1, 32'h0205_0007, 3, 4, 0, 0, 0);
    head_is("push3", 32'h0000_7057, 5, 7, 1, 3);
    cyc(1, 32'h0000_1057, 8, 9, 0, 0, 0);
    head_is("push4", 32'h0000_7057, 5, 7, 1, 4);
    chk("full.ready", 32'(inst_ready_out), 0);
    cyc(1, 32'h0000_2057, 10, 11, 0, 0, 0);
    head_is("offer5", 32'h0000_7057, 5, 7, 1, 4);

    // Ack the CONF head while full with a push offered: pop only, barrier engages.
    cyc(1, 32'h0000_2057, 10, 11, 1, 0, 0);
    head_is("ackfull", 32'h0000_0057, 1, 2, 0, 3);
    chk("ackfull.ready", 32'(inst_ready_out), 1);
    cyc(1, 32'h0000_2057, 10, 11, 0, 0, 0);
    head_is("waitpush", 32'h0000_0057, 1, 2, 0, 4);
    cyc(0, 0, 0, 0, 1, 0, 0);
    head_is("waitack", 32'h0000_0057, 1, 2, 0, 4);
    cyc(0, 0, 0, 0, 0, 1, 0);
    head_is("cfgdone", 32'h0000_0057, 1, 2, 1, 4);

    // Non-CONF heads issue back to back; push+pop keeps occupancy.
    cyc(0, 0, 0, 0, 1, 0, 0);
    head_is("ackB", 32'h0205_0007, 3, 4, 1, 3);
    cyc(1, 32'h0C05_72D7, 12, 13, 1, 0, 0);
    head_is("ackC_pushF", 32'h0000_1057, 8, 9, 1, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    head_is("ackD", 32'h0000_2057, 10, 11, 1, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    head_is("ackE", 32'h0C05_72D7, 12, 13, 1, 1);

    // vsetvli barrier with entries queued behind it.
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("ackF.valid", 32'(inst_valid), 0);
    chk("ackF.occ",   32'(occupancy), 0);
    cyc(1, 32'h0000_3057, 20, 21, 0, 0, 0);
    cyc(1, 32'h0000_0007, 22, 23, 0, 0, 0);
    head_is("barrier", 32'h0000_3057, 20, 21, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    head_is("release", 32'h0000_3057, 20, 21, 1, 2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    head_is("cfgrun", 32'h0000_3057, 20, 21, 1, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    head_is("ackG", 32'h0000_0007, 22, 23, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("ackH.valid", 32'(inst_valid), 0);
    chk("ackH.occ",   32'(occupancy), 0);

    // Flush in CFG_WAIT with occupancy 3 and a same-cycle push, ack and cfg_done.
    cyc(1, 32'h0C05_72D7, 30, 31, 0, 0, 0);
    cyc(1, 32'h0000_0057, 32, 33, 0, 0, 0);
    cyc(1, 32'h0205_0007, 34, 35, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    head_is("preflush", 32'h0000_0057, 32, 33, 0, 2);
    cyc(1, 32'h0000_4057, 36, 37, 0, 0, 0);
    chk("preflush.occ", 32'(occupancy), 3);
    cyc(1, 32'h0000_5057, 38, 39, 1, 1, 1);
    chk("flush.occ",   32'(occupancy), 0);
    chk("flush.valid", 32'(inst_valid), 0);
    chk("flush.ready", 32'(inst_ready_out), 1);
    cyc(1, 32'h0000_6057, 40, 41, 0, 0, 0);
    head_is("postflush", 32'h0000_6057, 40, 41, 1, 1);

    // Asynchronous reset in the middle of a push burst.
    cyc(1, 32'h0000_0057, 42, 43, 0, 0, 0);
    inst_valid_in = 1'b1;
    vec_inst_in   = 32'h0205_0007;
    rs1_data_in   = 44;
    rs2_data_in   = 45;
    #2 reset = 1'b0;
    #1;
    head_is("midrst", 0, 0, 0, 0, 0);
    chk("midrst.ready", 32'(inst_ready_out), 1);
    idle_inputs();
    #2 reset = 1'b1;
    @(posedge clk); #1;
    head_is("afterrst", 0, 0, 0, 0, 0);

    // Wrap-around: ten push/pop pairs through a single-entry pipeline.
    cyc(1, 32'h0000_0057, 100, 200, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 32'h0000_0057 | (32'(i) << 16), 32'(100 + i), 32'(200 + i), 1, 0, 0);
      head_is($sformatf("wrap%0d", i), 32'h0000_0057 | (32'(i) << 16),
              32'(100 + i), 32'(200 + i), 1, 1);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drain.occ",   32'(occupancy), 0);
    chk("drain.valid", 32'(inst_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
